enum_result_capture: RTL and testbench

//  Downstream stage for a generated enum-process block: samples its `out` value

---
 rtl/enum_capture_pkg.sv | 18 +
 rtl/enum_capture_fifo.sv | 66 ++++++
 rtl/enum_result_capture.sv | 108 ++++++++++
 tb/tb_enum_result_capture.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/enum_capture_pkg.sv
// Shared types, default widths and the enum range helper for the result-capture stage.
package enum_capture_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_e;

    localparam int unsigned DefDataW   = 6;
    localparam int unsigned DefDepth   = 4;
    localparam int unsigned DefEnumMax = 41;

    function automatic logic range_ok(input logic [31:0] value, input logic [31:0] max);
        return value <= max;
    endfunction

endpackage

// File: rtl/enum_capture_fifo.sv
// Storage, wrapping pointers and occupancy for the capture FIFO.
// The caller guarantees push only when not full (or popping) and pop only when non-empty.
module enum_capture_fifo #(
    parameter int unsigned DataW = 6,
    parameter int unsigned Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [DataW-1:0]           wr_data_i,
    output logic [DataW-1:0]           rd_data_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(Depth);

    logic [DataW-1:0] mem_q [Depth];
    logic [DataW-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_i) begin
            mem_d[wr_ptr_q] = wr_data_i;
            wr_ptr_d        = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        end

        // Saturating occupancy; simultaneous push+pop leaves it unchanged.
        if (push_i && !pop_i && count_q != CntMax) begin
            count_d = count_q + 1'b1;
        end else if (pop_i && !push_i && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/enum_result_capture.sv
// Captures enum-process results into a small FIFO with a sticky overflow flag.
// Optional range check against ENUM_MAX is enabled by defining ENUM_RANGE_CHECK_EN.
module enum_result_capture
    import enum_capture_pkg::*;
#(
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned DEPTH    = DefDepth,
    parameter int unsigned ENUM_MAX = DefEnumMax
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_err,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEPTH - 1);

    state_e          state_q, state_d;
    logic            overflow_q, overflow_d;
    logic            out_err_q, out_err_d;
    logic [CntW-1:0] fifo_count;
    logic            in_range;
    logic            accepted;
    logic            push_req;
    logic            push;
    logic            pop;
    logic            full;

    assign in_range = range_ok(32'(in_data), 32'(ENUM_MAX));

`ifdef ENUM_RANGE_CHECK_EN
    assign accepted  = in_range;
    assign out_err_d = in_valid & ~in_range;
`else
    logic unused_in_range;
    assign unused_in_range = in_range;
    assign accepted        = 1'b1;
    assign out_err_d       = 1'b0;
`endif

    assign full      = (state_q == FULL);
    assign out_valid = (state_q != EMPTY);
    assign push_req  = in_valid & accepted;
    assign pop       = out_valid & out_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push      = push_req & (~full | pop);

    // Rejected out-of-range values never count as overflow.
    assign overflow_d = overflow_q | (push_req & full & ~pop);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: begin
                if (push) state_d = PARTIAL;
            end
            PARTIAL: begin
                if (pop && !push && fifo_count == CntOne) begin
                    state_d = EMPTY;
                end else if (push && !pop && fifo_count == CntLast) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (pop && !push) state_d = PARTIAL;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            overflow_q <= 1'b0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
            out_err_q  <= out_err_d;
        end
    end

    enum_capture_fifo #(
        .DataW (DATA_W),
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .rst_i     (rst),
        .push_i    (push),
        .pop_i     (pop),
        .wr_data_i (in_data),
        .rd_data_o (out_data),
        .count_o   (fifo_count)
    );

    assign count    = fifo_count;
    assign overflow = overflow_q;
    assign out_err  = out_err_q;

endmodule

// File: tb/tb_enum_result_capture.sv
// Directed and randomized checks of enum_result_capture against a queue-based reference model.
module tb_enum_result_capture;

    localparam int DW    = 6;
    localparam int DEPTH = 4;
    localparam int EMAX  = 41;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_err;
    logic          overflow;
    logic [2:0]    count;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mq [$];
    logic          ov_m;
    logic          err_m;
    logic [DW-1:0] exp_drain [4];

    enum_result_capture #(
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .ENUM_MAX (EMAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_err   (out_err),
        .overflow  (overflow),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'(mq.size() != 0));
        chk({tag, ".count"}, 32'(count), 32'(mq.size()));
        chk({tag, ".overflow"}, 32'(overflow), 32'(ov_m));
        chk({tag, ".err"}, 32'(out_err), 32'(err_m));
        if (mq.size() != 0) chk({tag, ".data"}, 32'(out_data), 32'(mq[0]));
    endtask

    // Applies one cycle of stimulus and advances the model by the queue rules.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
        bit acc, full, pop, push_req;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        acc = 1'b1;
`ifdef ENUM_RANGE_CHECK_EN
        acc = (int'(d) <= EMAX);
`endif
        push_req = v && acc;
        full     = (mq.size() == DEPTH);
        pop      = r && (mq.size() != 0);
        err_m    = v && !acc;
        if (push_req && full && !pop) ov_m = 1'b1;
        if (pop) void'(mq.pop_front());
        if (push_req && (!full || pop)) mq.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        ov_m  = 1'b0;
        err_m = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        exp_drain = '{6'd41, 6'd10, 6'd1, 6'd5};

        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single push, latency 1.
        step(1'b1, 6'd30, 1'b0);
        check_all("t1");
        chk("t1.data30", 32'(out_data), 32'd30);
        chk("t1.count1", 32'(count), 32'd1);

        // Fill, then drop one while full.
        step(1'b1, 6'd41, 1'b0);
        step(1'b1, 6'd10, 1'b0);
        step(1'b1, 6'd1, 1'b0);
        check_all("t2.full");
        step(1'b1, 6'd7, 1'b0);
        check_all("t2.drop");
        chk("t2.overflow", 32'(overflow), 32'd1);
        step(1'b0, 6'd0, 1'b0);
        check_all("t2.sticky");

        // Push and pop together while full.
        step(1'b1, 6'd5, 1'b1);
        check_all("t3");
        chk("t3.head41", 32'(out_data), 32'd41);
        chk("t3.count4", 32'(count), 32'd4);

        // Out-of-range code.
        step(1'b1, 6'd42, 1'b0);
        check_all("t4");
`ifdef ENUM_RANGE_CHECK_EN
        chk("t4.err_pulse", 32'(out_err), 32'd1);
`else
        chk("t4.err_tied", 32'(out_err), 32'd0);
`endif
        step(1'b0, 6'd0, 1'b0);
        check_all("t4.after");

        // Drain in order.
        for (int i = 0; i < 4; i++) begin
            chk("t5.order", 32'(out_data), 32'(exp_drain[i]));
            step(1'b0, 6'd0, 1'b1);
            check_all("t5.drain");
        end
        chk("t5.empty", 32'(out_valid), 32'd0);
        chk("t5.count0", 32'(count), 32'd0);

        // Asynchronous reset with three entries held and overflow set.
        step(1'b1, 6'd3, 1'b0);
        step(1'b1, 6'd4, 1'b0);
        step(1'b1, 6'd6, 1'b0);
        check_all("t6.pre");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("t6.rst");
        chk("t6.overflow0", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 9) < 7), 6'($urandom_range(0, 63)),
                 1'($urandom_range(0, 9) < 4));
            check_all("rand");
        end

        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rand.rst");
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 6'd17, 1'b0);
        check_all("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
